mmio_stream_port: RTL and testbench

Memory-mapped responder on the CPU's 16-bit-address / 32-bit-data bus. Decodes a 16-word window and gives software a transmit FIFO that drains to an external valid/ready stream. Optionally adds a receive FIFO that fills from an inbound stream. Sits beside the main memory; the top level routes CPU reads from this block whenever `sel` is high.

---
 rtl/mmio_stream_port.sv | 155 +++++++++++++++
 tb/tb_mmio_stream_port.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_stream_port.sv
// Memory-mapped TX FIFO (and optional RX FIFO) bridging the CPU bus to valid/ready streams.
// Define MMIO_STREAM_RX_EN to build the receive FIFO and inbound stream.
module mmio_stream_port #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        rw,
  output logic        sel,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [7:0] DEPTH_CNT = 8'(DEPTH);

  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_RXDATA = 4'h1;
  localparam logic [3:0] REG_STATUS = 4'h2;
  localparam logic [3:0] REG_CTRL   = 4'h3;

  logic wr, wr_tx, wr_rx, wr_status, wr_ctrl, flush;

  assign sel       = (addr[15:4] == BASE_ADDR[15:4]);
  assign wr        = sel && !rw;
  assign wr_tx     = wr && (addr[3:0] == REG_TXDATA);
  assign wr_rx     = wr && (addr[3:0] == REG_RXDATA);
  assign wr_status = wr && (addr[3:0] == REG_STATUS);
  assign wr_ctrl   = wr && (addr[3:0] == REG_CTRL);
  assign flush     = wr_ctrl && din[1];

  // ---------------- TX FIFO ----------------
  logic [31:0]   tx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [7:0]    tx_count;
  logic          tx_en, tx_ovf;
  logic          tx_full, tx_empty, tx_push, tx_pop, tx_ovf_set;

  assign tx_full    = (tx_count == DEPTH_CNT);
  assign tx_empty   = (tx_count == 8'd0);
  assign tx_valid   = tx_en && !tx_empty;
  assign tx_data    = tx_valid ? tx_mem[tx_rd_ptr] : 32'd0;
  assign tx_pop     = tx_valid && tx_ready;
  // A full FIFO still accepts a push when the stream frees a slot in the same cycle.
  assign tx_push    = wr_tx && (!tx_full || tx_pop);
  assign tx_ovf_set = wr_tx && tx_full && !tx_pop;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= 8'd0;
      tx_en     <= 1'b0;
      tx_ovf    <= 1'b0;
    end else begin
      if (wr_ctrl) tx_en <= din[0];
      if (wr_status && din[4]) tx_ovf <= 1'b0;
      else if (tx_ovf_set)     tx_ovf <= 1'b1;
      if (flush) begin
        tx_wr_ptr <= '0;
        tx_rd_ptr <= '0;
        tx_count  <= 8'd0;
      end else begin
        if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
        if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
        if (tx_push && !tx_pop)      tx_count <= tx_count + 8'd1;
        else if (!tx_push && tx_pop) tx_count <= tx_count - 8'd1;
      end
    end
  end

  // NOTE: storage has no reset; the pointers and counts alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= din;
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]  rx_count;
  logic        rx_full, rx_empty, rx_unf;
  logic [31:0] rx_head;

`ifdef MMIO_STREAM_RX_EN
  logic [31:0]   rx_mem [DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic          rx_push, rx_pop;

  assign rx_full  = (rx_count == DEPTH_CNT);
  assign rx_empty = (rx_count == 8'd0);
  assign rx_ready = !rx_full;
  assign rx_head  = rx_empty ? 32'd0 : rx_mem[rx_rd_ptr];
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = wr_rx && !rx_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= 8'd0;
      rx_unf    <= 1'b0;
    end else begin
      if (wr_status && din[5])  rx_unf <= 1'b0;
      else if (wr_rx && rx_empty) rx_unf <= 1'b1;
      if (flush) begin
        rx_wr_ptr <= '0;
        rx_rd_ptr <= '0;
        rx_count  <= 8'd0;
      end else begin
        if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
        if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
        if (rx_push && !rx_pop)      rx_count <= rx_count + 8'd1;
        else if (!rx_push && rx_pop) rx_count <= rx_count - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end
`else
  logic unused_rx;

  assign unused_rx = ^{rx_valid, rx_data, wr_rx};
  assign rx_count  = 8'd0;
  assign rx_full   = 1'b0;
  assign rx_empty  = 1'b1;
  assign rx_unf    = 1'b0;
  assign rx_head   = 32'd0;
  assign rx_ready  = 1'b0;
`endif

  // ---------------- Read mux ----------------
  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    dout = 32'd0;
    if (sel) begin
      case (addr[3:0])
        REG_RXDATA: dout = rx_head;
        REG_STATUS: dout = {8'd0, rx_count, tx_count, 2'b00, rx_unf, tx_ovf,
                            rx_empty, rx_full, tx_empty, tx_full};
        REG_CTRL:   dout = {31'd0, tx_en};
        default:    dout = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_stream_port.sv
// Directed testbench for mmio_stream_port; covers both builds of MMIO_STREAM_RX_EN.
module tb_mmio_stream_port;

`ifdef MMIO_STREAM_RX_EN
  localparam bit RX = 1'b1;
`else
  localparam bit RX = 1'b0;
`endif

  localparam logic [15:0] A_TX   = 16'hFF00;
  localparam logic [15:0] A_RX   = 16'hFF01;
  localparam logic [15:0] A_STAT = 16'hFF02;
  localparam logic [15:0] A_CTRL = 16'hFF03;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [31:0] din, dout, tx_data, rx_data;
  logic        rw, sel, tx_valid, tx_ready, rx_valid, rx_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_stream_port #(.BASE_ADDR(16'hFF00), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .dout(dout), .rw(rw), .sel(sel),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the following negedge with the write applied.
  task automatic cpu_write(input logic [15:0] a, input logic [31:0] d);
    addr = a; din = d; rw = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rw = 1'b1; addr = 16'h0000; din = 32'd0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [31:0] d);
    addr = a; rw = 1'b1;
    #1;
    d = dout;
    addr = 16'h0000;
  endtask

  task automatic stream_in(input logic [31:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 32'd0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1; addr = 16'h0000; din = 32'd0; rw = 1'b1;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cpu_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000000A) begin n_fail++; $display("FAIL reset_status: got %h expected %h", d, 32'h0000000A); end
    cpu_read(A_CTRL, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", d); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    n_checks++; if (tx_data !== 32'd0) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 0", tx_data); end
    n_checks++; if (rx_ready !== RX) begin n_fail++; $display("FAIL reset_rx_ready: got %b expected %b", rx_ready, RX); end
  endtask

  task automatic test_decode;
    logic [31:0] d;
    addr = 16'hFE02; rw = 1'b1; #1;
    n_checks++; if (sel !== 1'b0) begin n_fail++; $display("FAIL decode_miss_sel: got %b expected 0", sel); end
    n_checks++; if (dout !== 32'd0) begin n_fail++; $display("FAIL decode_miss_dout: got %h expected 0", dout); end
    addr = 16'hFF07; #1;
    n_checks++; if (sel !== 1'b1) begin n_fail++; $display("FAIL decode_hit_sel: got %b expected 1", sel); end
    cpu_write(16'hFF07, 32'hFFFF_FFFF);
    cpu_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000000A) begin n_fail++; $display("FAIL decode_ignored_write: got %h expected %h", d, 32'h0000000A); end
  endtask

  task automatic test_tx_basic;
    logic [31:0] d;
    tx_ready = 1'b0;
    cpu_write(A_TX, 32'h11);
    cpu_write(A_TX, 32'h22);
    cpu_write(A_TX, 32'h33);
    cpu_read(A_STAT, d);
    n_checks++; if (d !== 32'h00000308) begin n_fail++; $display("FAIL tx_basic_status: got %h expected %h", d, 32'h00000308); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_basic_stalled: got %b expected 0", tx_valid); end
    cpu_read(A_TX, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL tx_basic_read_txdata: got %h expected 0", d); end
    tx_ready = 1'b1;
    cpu_write(A_CTRL, 32'h1);
    n_checks++; if (tx_data !== 32'h11) begin n_fail++; $display("FAIL tx_basic_word0: got %h expected 11", tx_data); end
    @(negedge clk);
    n_checks++; if (tx_data !== 32'h22) begin n_fail++; $display("FAIL tx_basic_word1: got %h expected 22", tx_data); end
    @(negedge clk);
    n_checks++; if (tx_data !== 32'h33) begin n_fail++; $display("FAIL tx_basic_word2: got %h expected 33", tx_data); end
    @(negedge clk);
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_basic_drained_valid: got %b expected 0", tx_valid); end
    cpu_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000000A) begin n_fail++; $display("FAIL tx_basic_empty: got %h expected %h", d, 32'h0000000A); end
    cpu_write(A_CTRL, 32'h0);
    tx_ready = 1'b0;
  endtask

  task automatic test_tx_overflow;
    logic [31:0] d;
    for (int i = 0; i < 17; i++) cpu_write(A_TX, 32'h100 + i);
    cpu_read(A_STAT, d);
    n_checks++; if (d !== 32'h00001019) begin n_fail++; $display("FAIL tx_ovf_status: got %h expected %h", d, 32'h00001019); end
    cpu_write(A_STAT, 32'h10);
    cpu_read(A_STAT, d);
    n_checks++; if (d !== 32'h00001009) begin n_fail++; $display("FAIL tx_ovf_clear: got %h expected %h", d, 32'h00001009); end
    tx_ready = 1'b1;
    cpu_write(A_CTRL, 32'h1);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (tx_data !== 32'h100 + i) begin n_fail++; $display("FAIL tx_ovf_drain[%0d]: got %h expected %h", i, tx_data, 32'h100 + i); end
      @(negedge clk);
    end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_ovf_lost_entry: got valid %b expected 0", tx_valid); end
    cpu_write(A_CTRL, 32'h0);
    tx_ready = 1'b0;
  endtask

  task automatic test_tx_full_push_pop;
    logic [31:0] d;
    logic [31:0] exp_q[$];
    cpu_write(A_CTRL, 32'h1);
    for (int i = 0; i < 16; i++) cpu_write(A_TX, 32'h200 + i);
    for (int i = 1; i < 16; i++) exp_q.push_back(32'h200 + i);
    exp_q.push_back(32'h2FF);
    tx_ready = 1'b1;
    cpu_write(A_TX, 32'h2FF);
    tx_ready = 1'b0;
    cpu_read(A_STAT, d);
    n_checks++; if (d !== 32'h00001009) begin n_fail++; $display("FAIL tx_full_pushpop_status: got %h expected %h", d, 32'h00001009); end
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (tx_data !== exp_q[i]) begin n_fail++; $display("FAIL tx_full_pushpop_drain[%0d]: got %h expected %h", i, tx_data, exp_q[i]); end
      @(negedge clk);
    end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_full_pushpop_empty: got %b expected 0", tx_valid); end
    cpu_write(A_CTRL, 32'h0);
    tx_ready = 1'b0;
  endtask

`ifdef MMIO_STREAM_RX_EN
  task automatic test_rx_basic;
    logic [31:0] d;
    stream_in(32'hA5A5A5A5);
    stream_in(32'h5A5A5A5A);
    cpu_read(A_RX, d);
    n_checks++; if (d !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rx_read_first: got %h expected A5A5A5A5", d); end
    @(negedge clk);
    cpu_read(A_RX, d);
    n_checks++; if (d !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rx_read_no_side_effect: got %h expected A5A5A5A5", d); end
    cpu_write(A_RX, 32'h0);
    cpu_read(A_RX, d);
    n_checks++; if (d !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL rx_read_after_pop: got %h expected 5A5A5A5A", d); end
    cpu_write(A_RX, 32'h0);
    cpu_write(A_RX, 32'h0);
    cpu_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000002A) begin n_fail++; $display("FAIL rx_underflow_status: got %h expected %h", d, 32'h0000002A); end
    cpu_read(A_RX, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rx_empty_read: got %h expected 0", d); end
    cpu_write(A_STAT, 32'h20);
    cpu_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000000A) begin n_fail++; $display("FAIL rx_unf_clear: got %h expected %h", d, 32'h0000000A); end
  endtask

  task automatic test_rx_wrap;
    logic [31:0] d;
    logic [31:0] q[$];
    for (int i = 0; i < 16; i++) begin
      stream_in(32'hC000_0000 + i);
      q.push_back(32'hC000_0000 + i);
    end
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_full_ready: got %b expected 0", rx_ready); end
    cpu_read(A_STAT, d);
    n_checks++; if (d !== 32'h00100006) begin n_fail++; $display("FAIL rx_full_status: got %h expected %h", d, 32'h00100006); end
    cpu_write(A_RX, 32'h0);
    void'(q.pop_front());
    for (int i = 0; i < 40; i++) begin
      cpu_read(A_RX, d);
      n_checks++;
      if (d !== q[0]) begin n_fail++; $display("FAIL rx_wrap_head[%0d]: got %h expected %h", i, d, q[0]); end
      rx_data = 32'hD000_0000 + i; rx_valid = 1'b1;
      cpu_write(A_RX, 32'h0);
      rx_valid = 1'b0;
      void'(q.pop_front());
      q.push_back(32'hD000_0000 + i);
    end
    cpu_read(A_STAT, d);
    n_checks++; if (d !== 32'h000F0002) begin n_fail++; $display("FAIL rx_wrap_count: got %h expected %h", d, 32'h000F0002); end
    while (q.size() > 0) begin
      cpu_read(A_RX, d);
      n_checks++;
      if (d !== q[0]) begin n_fail++; $display("FAIL rx_wrap_drain: got %h expected %h", d, q[0]); end
      cpu_write(A_RX, 32'h0);
      void'(q.pop_front());
    end
    cpu_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000000A) begin n_fail++; $display("FAIL rx_wrap_final: got %h expected %h", d, 32'h0000000A); end
  endtask
`else
  task automatic test_rx_disabled;
    logic [31:0] d;
    stream_in(32'h12345678);
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_off_ready: got %b expected 0", rx_ready); end
    cpu_read(A_RX, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rx_off_read: got %h expected 0", d); end
    cpu_write(A_RX, 32'h0);
    cpu_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000000A) begin n_fail++; $display("FAIL rx_off_status: got %h expected %h", d, 32'h0000000A); end
  endtask
`endif

  task automatic test_flush;
    logic [31:0] d;
    logic [31:0] exp_pre;
    exp_pre = RX ? 32'h00050500 : 32'h00000508;
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_write(A_TX, 32'h300 + i);
      stream_in(32'h400 + i);
    end
    cpu_read(A_STAT, d);
    n_checks++; if (d !== exp_pre) begin n_fail++; $display("FAIL flush_pre_status: got %h expected %h", d, exp_pre); end
    rx_data = 32'hEEEE; rx_valid = 1'b1;
    cpu_write(A_CTRL, 32'h3);
    rx_valid = 1'b0;
    cpu_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000000A) begin n_fail++; $display("FAIL flush_status: got %h expected %h", d, 32'h0000000A); end
    cpu_read(A_CTRL, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL flush_ctrl: got %h expected 1", d); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL flush_tx_valid: got %b expected 0", tx_valid); end
    cpu_write(A_CTRL, 32'h0);
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] d;
    cpu_write(A_TX, 32'h55);
    cpu_write(A_TX, 32'h66);
    cpu_write(A_STAT, 32'h0);
    cpu_write(A_CTRL, 32'h1);
    reset = 1'b1;
    #1;
    cpu_read(A_STAT, d);
    n_checks++; if (d !== 32'h0000000A) begin n_fail++; $display("FAIL midreset_status: got %h expected %h", d, 32'h0000000A); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_tx_valid: got %b expected 0", tx_valid); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cpu_read(A_CTRL, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_ctrl: got %h expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_tx_basic();
    test_tx_overflow();
    test_tx_full_push_pop();
`ifdef MMIO_STREAM_RX_EN
    test_rx_basic();
    test_rx_wrap();
`else
    test_rx_disabled();
`endif
    test_flush();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
